unit_risk: RTL and testbench



---
 rtl/risk_pkg.sv | 14 +
 rtl/risk_compare.sv | 22 ++
 rtl/unit_risk.sv | 164 ++++++++++++++++
 tb/tb_unit_risk.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/risk_pkg.sv
// Shared definitions for the unit_risk hazard unit: register-index width,
// default drain length and the FSM state encodings.
package risk_pkg;

  localparam int unsigned REG_W            = 5;
  localparam int unsigned DRAIN_CYCLES_DEF = 3;

  localparam int unsigned ST_W = 2;
  localparam logic [ST_W-1:0] ST_RUN    = 2'd0;
  localparam logic [ST_W-1:0] ST_EXTRA  = 2'd1;
  localparam logic [ST_W-1:0] ST_DRAIN  = 2'd2;
  localparam logic [ST_W-1:0] ST_HALTED = 2'd3;

endpackage

// File: rtl/risk_compare.sv
// Destination-vs-source register match for the hazard unit.
// Register 0 never matches; rt is only considered when the ID
// instruction actually reads it.
module risk_compare
  import risk_pkg::*;
(
  input  logic [REG_W-1:0] i_rd,
  input  logic [REG_W-1:0] i_rs,
  input  logic [REG_W-1:0] i_rt,
  input  logic             i_uses_rt,
  output logic             o_match
);

  logic rd_nonzero;

  // r0 is hardwired to zero, so writing it can never create a dependency
  always_comb begin
    rd_nonzero = (i_rd != '0);
    o_match    = rd_nonzero && ((i_rd == i_rs) || (i_uses_rt && (i_rd == i_rt)));
  end

endmodule

// File: rtl/unit_risk.sv
// Hazard detection unit for the 5-stage MIPS pipeline.
// Detects load-use and branch-in-ID data hazards, stalls PC and IF/ID,
// flushes IF/ID on taken control transfers and drains the pipe on HALT.
// Optional feature: define UNIT_RISK_STATS_EN to build the stall-cycle
// counter; otherwise o_stall_cycles is tied to zero.
module unit_risk
  import risk_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [REG_W-1:0] i_id_rs,
  input  logic [REG_W-1:0] i_id_rt,
  input  logic             i_id_uses_rt,
  input  logic             i_id_branch,
  input  logic             i_id_taken,
  input  logic             i_id_halt,
  input  logic             i_ex_mem_read,
  input  logic             i_ex_reg_write,
  input  logic [REG_W-1:0] i_ex_rd,
  input  logic             i_mem_mem_read,
  input  logic [REG_W-1:0] i_mem_rd,
  output logic             o_risk,
  output logic             o_pc_write,
  output logic             o_if_id_write,
  output logic             o_flush_if_id,
  output logic             o_halted,
  output logic [31:0]      o_stall_cycles
);

  localparam int unsigned CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

  logic [ST_W-1:0]  state_q, state_d;
  logic [CNT_W-1:0] drain_q, drain_d;

  logic match_ex, match_mem;
  logic load_use, br_alu, br_ld_ex, br_ld_mem, stall_run;

  logic risk_c, pc_write_c, if_id_write_c, flush_c, halted_c;

  risk_compare u_cmp_ex (
    .i_rd      (i_ex_rd),
    .i_rs      (i_id_rs),
    .i_rt      (i_id_rt),
    .i_uses_rt (i_id_uses_rt),
    .o_match   (match_ex)
  );

  risk_compare u_cmp_mem (
    .i_rd      (i_mem_rd),
    .i_rs      (i_id_rs),
    .i_rt      (i_id_rt),
    .i_uses_rt (i_id_uses_rt),
    .o_match   (match_mem)
  );

  // Hazard classification; a branch on a load still in EX needs two bubbles
  always_comb begin
    load_use  = i_ex_mem_read && match_ex;
    br_alu    = i_id_branch && i_ex_reg_write && !i_ex_mem_read && match_ex;
    br_ld_ex  = i_id_branch && load_use;
    br_ld_mem = i_id_branch && i_mem_mem_read && match_mem;
    stall_run = load_use || br_alu || br_ld_mem;
  end

  // Next state and pipeline controls; priority is stall > halt > flush
  always_comb begin
    state_d       = state_q;
    drain_d       = drain_q;
    risk_c        = 1'b0;
    pc_write_c    = 1'b1;
    if_id_write_c = 1'b1;
    flush_c       = 1'b0;
    halted_c      = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (stall_run) begin
          risk_c        = 1'b1;
          pc_write_c    = 1'b0;
          if_id_write_c = 1'b0;
          if (br_ld_ex) state_d = ST_EXTRA;
        end else if (i_id_halt) begin
          state_d = ST_DRAIN;
          drain_d = '0;
        end else if (i_id_taken) begin
          flush_c = 1'b1;
        end
      end
      ST_EXTRA: begin
        risk_c        = 1'b1;
        pc_write_c    = 1'b0;
        if_id_write_c = 1'b0;
        state_d       = ST_RUN;
      end
      ST_DRAIN: begin
        risk_c        = 1'b1;
        pc_write_c    = 1'b0;
        if_id_write_c = 1'b0;
        if (drain_q == DRAIN_LAST) state_d = ST_HALTED;
        else                       drain_d = drain_q + 1'b1;
      end
      ST_HALTED: begin
        risk_c        = 1'b1;
        pc_write_c    = 1'b0;
        if_id_write_c = 1'b0;
        halted_c      = 1'b1;
      end
      default: state_d = ST_RUN;
    endcase

    // Reset forces a free-running pipeline regardless of the stored state
    if (i_reset) begin
      risk_c        = 1'b0;
      pc_write_c    = 1'b1;
      if_id_write_c = 1'b1;
      flush_c       = 1'b0;
      halted_c      = 1'b0;
    end
  end

  // FSM and drain counter registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_RUN;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  assign o_risk        = risk_c;
  assign o_pc_write    = pc_write_c;
  assign o_if_id_write = if_id_write_c;
  assign o_flush_if_id = flush_c;
  assign o_halted      = halted_c;

`ifdef UNIT_RISK_STATS_EN
  logic        count_stall;
  logic [31:0] stall_cnt_q;

  // Only hazard stalls are counted; drain/halt bubbles are excluded
  always_comb begin
    count_stall = ((state_q == ST_RUN) && stall_run) || (state_q == ST_EXTRA);
  end

  // Saturating stall-cycle counter
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      stall_cnt_q <= '0;
    end else if (count_stall && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign o_stall_cycles = i_reset ? '0 : stall_cnt_q;
`else
  assign o_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_unit_risk.sv
// Directed self-checking bench for unit_risk.
module tb_unit_risk;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs, id_rt, ex_rd, mem_rd;
  logic        id_uses_rt, id_branch, id_taken, id_halt;
  logic        ex_mem_read, ex_reg_write, mem_mem_read;
  logic        risk, pc_write, if_id_write, flush, halted;
  logic [31:0] stall_cycles;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

`ifdef UNIT_RISK_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  always #5 clk = ~clk;

  unit_risk #(.DRAIN_CYCLES(3)) dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_id_rs        (id_rs),
    .i_id_rt        (id_rt),
    .i_id_uses_rt   (id_uses_rt),
    .i_id_branch    (id_branch),
    .i_id_taken     (id_taken),
    .i_id_halt      (id_halt),
    .i_ex_mem_read  (ex_mem_read),
    .i_ex_reg_write (ex_reg_write),
    .i_ex_rd        (ex_rd),
    .i_mem_mem_read (mem_mem_read),
    .i_mem_rd       (mem_rd),
    .o_risk         (risk),
    .o_pc_write     (pc_write),
    .o_if_id_write  (if_id_write),
    .o_flush_if_id  (flush),
    .o_halted       (halted),
    .o_stall_cycles (stall_cycles)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic r, input logic pcw,
                            input logic ifw, input logic fl, input logic h);
    check({tag, ".risk"},   {31'd0, risk},        {31'd0, r});
    check({tag, ".pcw"},    {31'd0, pc_write},    {31'd0, pcw});
    check({tag, ".ifidw"},  {31'd0, if_id_write}, {31'd0, ifw});
    check({tag, ".flush"},  {31'd0, flush},       {31'd0, fl});
    check({tag, ".halted"}, {31'd0, halted},      {31'd0, h});
  endtask

  task automatic idle();
    id_rs = '0; id_rt = '0; ex_rd = '0; mem_rd = '0;
    id_uses_rt = 0; id_branch = 0; id_taken = 0; id_halt = 0;
    ex_mem_read = 0; ex_reg_write = 0; mem_mem_read = 0;
  endtask

  // Advance to just after the next rising edge; inputs are then applied
  // and outputs sampled mid-cycle.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst = 1'b1;
    // Hazard present while in reset: outputs must still be forced
    ex_mem_read = 1; ex_rd = 5'd8; id_rs = 5'd8;
    next_cycle();
    next_cycle();
    settle();
    expect_out("reset", 0, 1, 1, 0, 0);
    check("reset.stall_cnt", stall_cycles, 32'd0);

    next_cycle();
    rst = 1'b0;
    idle();
    settle();
    expect_out("idle", 0, 1, 1, 0, 0);

    // Five plain load-use stalls: lw $t0 in EX, add rs=$t0 in ID
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      ex_mem_read = 1; ex_rd = 5'd8; id_rs = 5'd8;
      settle();
      expect_out($sformatf("lu%0d", i), 1, 0, 0, 0, 0);
      next_cycle();
      idle();
      settle();
      expect_out($sformatf("lu%0d_after", i), 0, 1, 1, 0, 0);
    end
    check("stats5", stall_cycles, STATS ? 32'd5 : 32'd0);

    // lw to r0 with rs=0: never a hazard
    next_cycle();
    ex_mem_read = 1; ex_rd = 5'd0; id_rs = 5'd0;
    settle();
    expect_out("r0", 0, 1, 1, 0, 0);

    // rt matches but instruction does not read rt
    next_cycle();
    idle();
    ex_mem_read = 1; ex_rd = 5'd7; id_rt = 5'd7; id_rs = 5'd3; id_uses_rt = 0;
    settle();
    expect_out("rt_unused", 0, 1, 1, 0, 0);

    // beq rt=9 with lw $9 in EX: two stall cycles, EXTRA ignores inputs
    next_cycle();
    idle();
    ex_mem_read = 1; ex_rd = 5'd9; id_rt = 5'd9; id_uses_rt = 1; id_branch = 1;
    settle();
    expect_out("brld_run", 1, 0, 0, 0, 0);
    next_cycle();
    idle();
    id_taken = 1;
    settle();
    expect_out("brld_extra", 1, 0, 0, 0, 0);
    next_cycle();
    idle();
    id_branch = 1; id_taken = 1; id_uses_rt = 1; id_rt = 5'd9;
    settle();
    expect_out("brld_taken", 0, 1, 1, 1, 0);
    next_cycle();
    idle();
    settle();
    expect_out("brld_done", 0, 1, 1, 0, 0);

    // Branch on ALU result in EX: one stall; non-branch on same: none
    next_cycle();
    id_branch = 1; ex_reg_write = 1; ex_rd = 5'd5; id_rs = 5'd5;
    settle();
    expect_out("bralu", 1, 0, 0, 0, 0);
    next_cycle();
    id_branch = 0;
    settle();
    expect_out("alu_nobr", 0, 1, 1, 0, 0);

    // Branch on load in MEM: one stall
    next_cycle();
    idle();
    id_branch = 1; mem_mem_read = 1; mem_rd = 5'd12; id_rs = 5'd12;
    settle();
    expect_out("brmem", 1, 0, 0, 0, 0);

    // Taken jump with load-use: stall wins, flush waits a cycle
    next_cycle();
    idle();
    id_taken = 1; ex_mem_read = 1; ex_rd = 5'd4; id_rs = 5'd4;
    settle();
    expect_out("jmp_lu", 1, 0, 0, 0, 0);
    next_cycle();
    idle();
    id_taken = 1; id_rs = 5'd4;
    settle();
    expect_out("jmp_flush", 0, 1, 1, 1, 0);
    // 5 + 2 (beq) + 1 (alu) + 1 (mem) + 1 (jump)
    check("stats10", stall_cycles, STATS ? 32'd10 : 32'd0);

    // Reset asserted during EXTRA: no residual stall, counter cleared
    next_cycle();
    idle();
    ex_mem_read = 1; ex_rd = 5'd9; id_rs = 5'd9; id_branch = 1;
    settle();
    expect_out("rx_run", 1, 0, 0, 0, 0);
    next_cycle();
    idle();
    rst = 1'b1;
    settle();
    expect_out("rx_reset", 0, 1, 1, 0, 0);
    check("rx_reset.cnt", stall_cycles, 32'd0);
    next_cycle();
    rst = 1'b0;
    settle();
    expect_out("rx_after", 0, 1, 1, 0, 0);
    check("rx_after.cnt", stall_cycles, 32'd0);

    // HALT while stalled is held off, then accepted; taken is overridden
    next_cycle();
    id_halt = 1; ex_mem_read = 1; ex_rd = 5'd8; id_rs = 5'd8;
    settle();
    expect_out("halt_stalled", 1, 0, 0, 0, 0);
    next_cycle();
    idle();
    id_halt = 1; id_taken = 1;
    settle();
    expect_out("halt_N", 0, 1, 1, 0, 0);
    for (int i = 1; i <= 3; i++) begin
      next_cycle();
      idle();
      settle();
      expect_out($sformatf("drain%0d", i), 1, 0, 0, 0, 0);
    end
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      idle();
      id_taken = 1; ex_mem_read = 1; ex_rd = 5'd8; id_rs = 5'd8;
      settle();
      expect_out($sformatf("halted%0d", i), 1, 0, 0, 0, 1);
    end
    check("halt.cnt", stall_cycles, STATS ? 32'd1 : 32'd0);

    // Reset leaves HALTED
    next_cycle();
    idle();
    rst = 1'b1;
    settle();
    expect_out("hr_reset", 0, 1, 1, 0, 0);
    next_cycle();
    rst = 1'b0;
    settle();
    expect_out("hr_run", 0, 1, 1, 0, 0);
    next_cycle();
    id_taken = 1;
    settle();
    expect_out("hr_flush", 0, 1, 1, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
